// File: rtl/serv_mem_sched_pkg.sv
// Shared types and constants for the SERV single-port memory scheduler.
package serv_mem_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [3:0] SERV_MEM_SCHED_SEL_ALL = 4'hf;

endpackage

// File: rtl/serv_mem_sched_tmo.sv
// Watchdog cycle counter: cleared by i_clr, counts while i_en, flags when the count reaches TMO_CYCLES.
module serv_mem_sched_tmo #(
  parameter int TMO_CYCLES = 1023,
  parameter int TMO_W      = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr)
      cnt <= '0;
    else if (i_en && !o_expired)
      cnt <= cnt + TMO_W'(1);
  end

  assign o_expired = (cnt == TMO_W'(TMO_CYCLES));

endmodule

// File: rtl/serv_mem_sched.sv
// Shares one Wishbone-classic port between SERV ibus and dbus; dbus wins ties, grant is registered.
// Optional watchdog enabled by defining SERV_MEM_SCHED_TMO_EN.
module serv_mem_sched
  import serv_mem_sched_pkg::*;
#(
  parameter int TMO_CYCLES = 1023,
  parameter int TMO_W      = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_busy,
  output logic        o_tmo
);

  state_t state;
  logic   gnt_i, gnt_d, grant;
  logic   expire, term;

  assign gnt_i = (state == GNT_I);
  assign gnt_d = (state == GNT_D);
  assign grant = gnt_i || gnt_d;

`ifdef SERV_MEM_SCHED_TMO_EN
  logic tmo_hit;

  // Counter sits at zero while idle, so it reads 0 in the first grant cycle.
  serv_mem_sched_tmo #(
    .TMO_CYCLES(TMO_CYCLES),
    .TMO_W     (TMO_W)
  ) u_tmo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (!grant),
    .i_en     (grant && !i_wb_ack),
    .o_expired(tmo_hit)
  );

  assign expire = grant && tmo_hit && !i_wb_ack;
  assign o_tmo  = expire && !i_rst;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^{TMO_CYCLES, TMO_W};
  assign expire = 1'b0;
  assign o_tmo  = 1'b0;
`endif

  assign term = i_wb_ack || expire;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (i_dbus_cyc)      state <= GNT_D;
          else if (i_ibus_cyc) state <= GNT_I;
        end
        GNT_I:   if (term || !i_ibus_cyc) state <= IDLE;
        GNT_D:   if (term || !i_dbus_cyc) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Acks pass straight through from the slave, gated by the registered grant.
  assign o_ibus_ack = gnt_i && term && !i_rst;
  assign o_dbus_ack = gnt_d && term && !i_rst;
  assign o_ibus_rdt = i_wb_rdt;
  assign o_dbus_rdt = i_wb_rdt;
  assign o_busy     = (state != IDLE);

  always_comb begin
    o_wb_cyc = grant;
    o_wb_adr = '0;
    o_wb_dat = '0;
    o_wb_sel = '0;
    o_wb_we  = 1'b0;
    if (gnt_d) begin
      o_wb_adr = i_dbus_adr;
      o_wb_dat = i_dbus_dat;
      o_wb_sel = i_dbus_sel;
      o_wb_we  = i_dbus_we;
    end else if (gnt_i) begin
      o_wb_adr = i_ibus_adr;
      o_wb_sel = SERV_MEM_SCHED_SEL_ALL;
    end
  end

endmodule

// File: tb/tb_serv_mem_sched.sv
// Self-checking bench for serv_mem_sched: vector table, directed corner sequences, randomized transactions.
module tb_serv_mem_sched;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_ibus_adr, i_dbus_adr, i_dbus_dat, i_wb_rdt;
  logic        i_ibus_cyc, i_dbus_cyc, i_dbus_we, i_wb_ack;
  logic [3:0]  i_dbus_sel;
  logic [31:0] o_ibus_rdt, o_dbus_rdt, o_wb_adr, o_wb_dat;
  logic        o_ibus_ack, o_dbus_ack, o_wb_we, o_wb_cyc, o_busy, o_tmo;
  logic [3:0]  o_wb_sel;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  serv_mem_sched #(.TMO_CYCLES(8), .TMO_W(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc), .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack),
    .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel), .i_dbus_we(i_dbus_we),
    .i_dbus_cyc(i_dbus_cyc), .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc),
    .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack), .o_busy(o_busy), .o_tmo(o_tmo)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " cyc"},  o_wb_cyc,   0);
    chk({nm, " busy"}, o_busy,     0);
    chk({nm, " iack"}, o_ibus_ack, 0);
    chk({nm, " dack"}, o_dbus_ack, 0);
  endtask

  // Transaction-level model: requests present together are served dbus first,
  // each grant lasting wait+1 cycles, separated by exactly one idle cycle.
  task automatic run_pair(input bit ri, input bit rd, input logic [31:0] ia, input logic [31:0] da,
                          input logic [31:0] dd, input logic [3:0] ds, input logic dw,
                          input int wi, input int wd);
    int order[$];
    i_ibus_adr = ia; i_dbus_adr = da; i_dbus_dat = dd; i_dbus_sel = ds; i_dbus_we = dw;
    i_ibus_cyc = ri; i_dbus_cyc = rd; i_wb_ack = 1'b0;
    if (rd) order.push_back(1);
    if (ri) order.push_back(0);
    foreach (order[k]) begin
      bit g;
      int w;
      logic [31:0] rdt;
      g = order[k][0];
      w = g ? wd : wi;
      tick();
      for (int j = 0; j <= w; j++) begin
        if (j == w) begin
          rdt = $urandom;
          i_wb_ack = 1'b1;
          i_wb_rdt = rdt;
        end
        #1;
        chk("pair cyc", o_wb_cyc, 1);
        chk("pair adr", o_wb_adr, g ? da : ia);
        chk("pair sel", o_wb_sel, g ? ds : 4'hf);
        chk("pair we",  o_wb_we,  g ? dw : 1'b0);
        if (g) chk("pair dat", o_wb_dat, dd);
        chk("pair iack", o_ibus_ack, (j == w) && !g);
        chk("pair dack", o_dbus_ack, (j == w) && g);
        if (j == w) chk("pair rdt", g ? o_dbus_rdt : o_ibus_rdt, rdt);
        if (j < w) tick();
      end
      tick();
      if (g) i_dbus_cyc = 1'b0; else i_ibus_cyc = 1'b0;
      i_wb_ack = 1'b0;
      #1;
      chk_idle("pair gap");
    end
  endtask

  typedef struct {
    logic        ri, rd, ack, dw;
    logic [31:0] ia, da, dd;
    logic [3:0]  ds;
    logic [31:0] exp_adr;
    logic [3:0]  exp_sel;
    logic        exp_we, exp_iack, exp_dack;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1, 0, 1, 0, 32'h100,      32'h0,  32'h0,        4'h0, 32'h100,      4'hf, 0, 1, 0};
    vecs[1] = '{0, 1, 1, 1, 32'h0,        32'h8000, 32'hdeadbeef, 4'h3, 32'h8000,   4'h3, 1, 0, 1};
    vecs[2] = '{1, 1, 0, 0, 32'h200,      32'h40, 32'h11223344, 4'hc, 32'h40,       4'hc, 0, 0, 0};
    vecs[3] = '{1, 0, 0, 1, 32'hfffffffc, 32'h44, 32'h55,       4'h1, 32'hfffffffc, 4'hf, 0, 0, 0};
    vecs[4] = '{0, 1, 1, 0, 32'h9,        32'h0,  32'h0,        4'h0, 32'h0,        4'h0, 0, 0, 1};
    vecs[5] = '{1, 1, 1, 1, 32'h4,        32'h8,  32'hcafef00d, 4'hf, 32'h8,        4'hf, 1, 0, 1};

    i_rst = 1'b1; i_ibus_cyc = 0; i_dbus_cyc = 0; i_wb_ack = 0; i_dbus_we = 0;
    i_ibus_adr = 0; i_dbus_adr = 0; i_dbus_dat = 0; i_dbus_sel = 0; i_wb_rdt = 0;
    repeat (3) tick();
    chk_idle("reset");
    chk("reset tmo", o_tmo, 0);
    i_rst = 1'b0;
    tick();

    // Vector table: idle cycle with the vector's inputs (ack ignored), then one grant cycle.
    foreach (vecs[v]) begin
      i_ibus_adr = vecs[v].ia; i_dbus_adr = vecs[v].da; i_dbus_dat = vecs[v].dd;
      i_dbus_sel = vecs[v].ds; i_dbus_we = vecs[v].dw; i_wb_ack = vecs[v].ack;
      i_wb_rdt = 32'ha5a50000 + v;
      i_ibus_cyc = vecs[v].ri; i_dbus_cyc = vecs[v].rd;
      #1;
      chk_idle("vec idle");
      chk("vec idle adr", o_wb_adr, 0);
      chk("vec idle dat", o_wb_dat, 0);
      chk("vec idle sel", o_wb_sel, 0);
      chk("vec idle we",  o_wb_we,  0);
      tick();
      chk("vec cyc",  o_wb_cyc,   1);
      chk("vec adr",  o_wb_adr,   vecs[v].exp_adr);
      chk("vec sel",  o_wb_sel,   vecs[v].exp_sel);
      chk("vec we",   o_wb_we,    vecs[v].exp_we);
      chk("vec iack", o_ibus_ack, vecs[v].exp_iack);
      chk("vec dack", o_dbus_ack, vecs[v].exp_dack);
      i_ibus_cyc = 0; i_dbus_cyc = 0; i_wb_ack = 0;
      tick();
      chk_idle("vec after");
    end

    // Lone ibus read, slave acks in the third grant cycle; dbus fields must not leak.
    run_pair(1, 0, 32'h100, 32'h300, 32'h77, 4'h3, 1'b1, 2, 0);
    // Simultaneous requests: dbus write first, ibus after one idle cycle.
    run_pair(1, 1, 32'h200, 32'h8000, 32'hdeadbeef, 4'h3, 1'b1, 1, 0);

    // Reset mid-grant.
    i_ibus_adr = 32'h400; i_ibus_cyc = 1;
    tick();
    chk("rst grant cyc", o_wb_cyc, 1);
    i_rst = 1'b1;
    tick();
    chk_idle("rst mid");
    i_rst = 1'b0; i_ibus_cyc = 0;
    tick();

    // Requester drops cyc without ack.
    i_dbus_cyc = 1;
    tick();
    chk("drop busy", o_busy, 1);
    i_dbus_cyc = 0;
    tick();
    chk_idle("drop");

    // Ack coincident with requester drop is still forwarded.
    i_dbus_cyc = 1;
    tick();
    i_dbus_cyc = 0; i_wb_ack = 1; i_wb_rdt = 32'h0badf00d;
    #1;
    chk("ackdrop dack", o_dbus_ack, 1);
    chk("ackdrop rdt",  o_dbus_rdt, 32'h0badf00d);
    tick();
    i_wb_ack = 0;
    #1;
    chk_idle("ackdrop after");

`ifdef SERV_MEM_SCHED_TMO_EN
    for (int mode = 0; mode < 2; mode++) begin
      i_dbus_cyc = 1; i_dbus_adr = 32'h5000;
      tick();
      for (int c = 0; c < 8; c++) begin
        chk("tmo early tmo",  o_tmo, 0);
        chk("tmo early dack", o_dbus_ack, 0);
        tick();
      end
      if (mode == 1) i_wb_ack = 1;
      #1;
      chk("tmo expiry tmo",  o_tmo, mode == 0);
      chk("tmo expiry dack", o_dbus_ack, 1);
      chk("tmo expiry iack", o_ibus_ack, 0);
      i_dbus_cyc = 0;
      tick();
      i_wb_ack = 0;
      #1;
      chk_idle("tmo after");
      chk("tmo after tmo", o_tmo, 0);
    end
`else
    i_dbus_cyc = 1;
    tick();
    repeat (12) tick();
    chk("notmo busy", o_busy, 1);
    chk("notmo tmo",  o_tmo, 0);
    chk("notmo dack", o_dbus_ack, 0);
    i_dbus_cyc = 0;
    tick();
    chk_idle("notmo after");
`endif

    for (int t = 0; t < 40; t++) begin
      bit ri, rd;
      ri = $urandom_range(0, 1);
      rd = $urandom_range(0, 1);
      if (!ri && !rd) ri = 1;
      run_pair(ri, rd, $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serv_mem_sched.md
# serv_mem_sched

Single-port memory scheduler sharing one Wishbone-classic memory port between the SERV instruction bus (`ibus`) and data bus (`dbus`). The grant is registered. A three-state FSM sequences each transaction from request to acknowledge. An optional watchdog terminates stuck transactions. It sits between the core's `o_ibus_cyc`/`o_dbus_cyc` outputs and the SoC memory or interconnect.

## Interface
Parameters:
- `TMO_CYCLES`, default 1023: watchdog limit in cycles. Only used with `SERV_MEM_SCHED_TMO_EN`.
- `TMO_W`, default 10: watchdog counter width. Must satisfy 2^TMO_W > TMO_CYCLES.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_ibus_adr`  in  32  instruction address.
- `i_ibus_cyc`  in  1  instruction request.
- `o_ibus_rdt`  out  32  instruction read data.
- `o_ibus_ack`  out  1  instruction acknowledge.
- `i_dbus_adr`  in  32  data address.
- `i_dbus_dat`  in  32  write data.
- `i_dbus_sel`  in  4  byte enables.
- `i_dbus_we`  in  1  write enable.
- `i_dbus_cyc`  in  1  data request.
- `o_dbus_rdt`  out  32  data read data.
- `o_dbus_ack`  out  1  data acknowledge.
- `o_wb_adr`  out  32  memory address.
- `o_wb_dat`  out  32  memory write data.
- `o_wb_sel`  out  4  memory byte enables.
- `o_wb_we`  out  1  memory write enable.
- `o_wb_cyc`  out  1  memory cycle/strobe.
- `i_wb_rdt`  in  32  memory read data.
- `i_wb_ack`  in  1  memory acknowledge.
- `o_busy`  out  1  FSM not in IDLE.
- `o_tmo`  out  1  one-cycle watchdog-expiry pulse. Tied 0 without the macro.

## Operation
- FSM states: IDLE, GNT_I, GNT_D.
- IDLE:
  - `i_dbus_cyc` -> GNT_D.
  - Else `i_ibus_cyc` -> GNT_I.
  - Else stay in IDLE.
  - dbus has fixed priority when both request.
- GNT_x:
  - Memory port driven from the granted master. `o_wb_cyc` = 1.
  - `o_wb_we` is forced 0 in GNT_I. `o_wb_sel` is forced 4'hf in GNT_I.
  - `o_wb_dat`, `o_wb_sel` and `o_wb_we` come from dbus in GNT_D.
  - On `i_wb_ack`: `o_x_ack` = 1 in the same cycle, combinational pass-through. Next state IDLE.
  - Granted master drops `cyc` without ack: return to IDLE next cycle. No ack is issued.
- IDLE output values:
  - `o_wb_cyc` = 0, `o_wb_we` = 0.
  - `o_wb_adr`, `o_wb_dat`, `o_wb_sel` = 0.
- `o_ibus_rdt` and `o_dbus_rdt` both carry `i_wb_rdt` unconditionally. Only the ack qualifies the data.
- Acks are never issued to the non-granted master.
- `i_wb_ack` in IDLE is ignored.

## Timing
- Reset state: FSM IDLE, `o_wb_cyc` = 0, both acks 0, `o_busy` = 0, `o_tmo` = 0, watchdog count 0.
- Request to grant latency: a request sampled high at edge N gives `o_wb_cyc` = 1 from cycle N+1.
- Minimum transaction: 3 cycles, from `cyc` rise to next IDLE, with a zero-wait slave acking in the first grant cycle.
- Back-to-back: after an ack there is one mandatory IDLE cycle before re-arbitration. A waiting master is granted the cycle after that IDLE.
- Simultaneous `i_wb_ack` and requester drop: the ack is still forwarded, then IDLE.
- `i_rst` mid-transaction: IDLE next cycle, `o_wb_cyc` dropped, no ack generated.

## Configuration
- `SERV_MEM_SCHED_TMO_EN` defined:
  - Counter clears on entry to GNT_x and increments each grant cycle without ack.
  - At count == `TMO_CYCLES`: assert `o_x_ack` to the granted master for one cycle, pulse `o_tmo`, then IDLE.
  - Read data in that cycle is whatever `i_wb_rdt` carries. The master must treat it as garbage.
  - A real ack in the same cycle as expiry takes precedence. `o_tmo` stays 0.
- `SERV_MEM_SCHED_TMO_EN` undefined:
  - No counter logic.
  - `o_tmo` tied 0.
  - A grant waits indefinitely.

## Structure
- Package `serv_mem_sched_pkg` holds:
  - The state enum: IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2.
  - The constant `SERV_MEM_SCHED_SEL_ALL` = 4'hf.
- Sub-module `serv_mem_sched_tmo`: watchdog counter with clear, enable, and expiry output. Instantiated only under the macro.
- Top level contains the FSM and the output muxing.

## Test plan
- Lone ibus read: `i_ibus_adr` = 0x100, slave acks 2 cycles after `o_wb_cyc`. `o_wb_adr` = 0x100, `o_wb_we` = 0, `o_wb_sel` = 0xf. `o_ibus_ack` is coincident with `i_wb_ack` and carries `o_ibus_rdt` = slave data. IDLE follows.
- Simultaneous requests: ibus 0x200 and dbus write 0x8000 with data 0xdeadbeef and sel 0x3. dbus is granted first with all fields passed through. ibus is granted after ack plus one IDLE cycle.
- No ack leak: `i_wb_ack` asserted while IDLE gives `o_ibus_ack` = `o_dbus_ack` = 0. During GNT_D, `o_ibus_ack` is never 1.
- Reset mid-grant: `i_rst` asserted in GNT_I gives `o_wb_cyc` = 0 and `o_busy` = 0 next cycle, with no ack.
- With the macro and `TMO_CYCLES` = 8: slave never acks. `o_dbus_ack` and `o_tmo` pulse exactly 8 grant cycles after `o_wb_cyc` rises.
- With the macro, ack on the expiry cycle: `o_tmo` = 0 and a normal ack.
